prefetch_unit: RTL and testbench
================================

PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the instruction queue depth in entries (power of two, 2..16).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0, giving the word address of the first fetch after reset.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port imem_req  output  1  the fetch request strobe, valid for one cycle per request.
REQ-006 The block SHALL have port imem_addr  output  32  the word address of the request, meaningful while imem_req=1.
REQ-007 The block SHALL have port imem_rvalid  input  1  the memory response strobe.
REQ-008 The block SHALL have port imem_rdata  input  32  the instruction word, meaningful while imem_rvalid=1.
REQ-009 The block SHALL have port redirect_valid  input  1  the branch/jump redirect strobe from the execute stage.
REQ-010 The block SHALL have port redirect_pc  input  32  the redirect target word address.
REQ-011 The block SHALL have port instr_valid  output  1  the queue-head-valid signal towards decode.
REQ-012 The block SHALL have port instr  output  32  the queue-head instruction word.
REQ-013 The block SHALL have port instr_pc  output  32  the word address of the queue-head instruction.
REQ-014 The block SHALL have port instr_ready  input  1  the decode-accepts signal; a transfer occurs when instr_valid and instr_ready are both 1.

Function
REQ-015 Addresses SHALL be word addresses; the fetch PC SHALL increment by 1 per issued request, wrapping 32'hFFFFFFFF to 0.
REQ-016 The block SHALL keep at most one request outstanding and SHALL run a 3-state FSM: IDLE (none outstanding), WAIT (outstanding, response kept) and DROP (outstanding, response discarded).
REQ-017 imem_req SHALL be combinational: 1 iff state=IDLE, queue count + 0 < DEPTH, reset=0 and redirect_valid=0; imem_addr SHALL equal the fetch PC.
REQ-018 When a request is issued, the FSM SHALL move IDLE->WAIT and the fetch PC SHALL advance; the request's PC SHALL be held for tagging the response.
REQ-019 In WAIT, imem_rvalid SHALL push {imem_rdata, tagged PC} into the queue and move the FSM to IDLE; response latency SHALL be 1 or more cycles, unbounded.
REQ-020 In DROP, imem_rvalid SHALL discard the data, leave the queue unchanged and move the FSM to IDLE.
REQ-021 imem_rvalid in IDLE SHALL be ignored.
REQ-022 A pushed entry SHALL become visible at instr_valid the cycle after imem_rvalid; there SHALL be no bypass path.
REQ-023 instr_valid SHALL equal (count != 0), with instr and instr_pc driven from the head entry; both SHALL be 0 when the queue is empty.
REQ-024 Queue push and pop SHALL be allowed in the same cycle, leaving count unchanged; a pop SHALL occur only on transfer.
REQ-025 When full (count = DEPTH), no request SHALL issue; an in-flight response SHALL always have space because issue requires count < DEPTH.
REQ-026 redirect_valid SHALL take effect at the next edge: the queue SHALL be flushed, the fetch PC SHALL be set to redirect_pc, WAIT SHALL become DROP, and IDLE and DROP SHALL be kept.
REQ-027 A transfer in the redirect cycle SHALL count as completed; any imem_rvalid in the redirect cycle SHALL be discarded.
REQ-028 A redirect SHALL suppress imem_req in its own cycle; the first fetch at redirect_pc SHALL occur no earlier than the next cycle.
REQ-029 Back-to-back redirects SHALL use the last value of redirect_pc.

Reset
REQ-030 While reset=1, the queue SHALL be emptied, the FSM set to IDLE, the fetch PC set to RESET_PC, and instr_valid, instr, instr_pc and imem_req SHALL be 0.
REQ-031 reset SHALL dominate redirect_valid and imem_rvalid, and a response to a request issued before reset SHALL be dropped, with the FSM treating it as DROP after reset if it arrives.

Verification
REQ-032 Release reset, hold instr_ready=0, and memory responds one cycle later with data 32'h1000+addr -> requests at addresses 0,1,2,3 issue, then imem_req stays 0 with count=4 and head instr=32'h1000, instr_pc=0.
REQ-033 Hold instr_ready=1 with 3-cycle memory latency -> instructions with instr_pc 0,1,2,... appear in order, each the cycle after its rvalid, with no duplicates or gaps.
REQ-034 Assert a redirect to 32'h40 while a request for address 5 is outstanding -> the queue empties next cycle, the address-5 response is dropped, the next imem_addr=32'h40, and the first instr_pc after the redirect is 32'h40.
REQ-035 Assert redirect_valid and imem_rvalid in the same cycle -> the rvalid data never appears at instr and the FSM is IDLE next cycle.
REQ-036 Assert reset mid-stream with 2 entries queued and one request outstanding -> instr_valid=0 next cycle, the late rvalid is ignored, and the first fetch after reset is at RESET_PC.
REQ-037 Set the fetch PC to 32'hFFFFFFFF via redirect -> the fetch sequence is 32'hFFFFFFFF then 32'h0.

Source files
------------

// File: rtl/prefetch_unit.sv
// Instruction prefetch unit: single-outstanding fetch FSM feeding a DEPTH-entry
// instruction queue, with redirect flush and stale-response dropping.
module prefetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   tag_pc;
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic          issue;
  logic          push;
  logic          pop;

  always_comb begin
    issue       = (state == IDLE) && (count < DEPTH_C) && !reset && !redirect_valid;
    imem_req    = issue;
    imem_addr   = fetch_pc;
    instr_valid = (count != '0) && !reset;
    if (instr_valid) begin
      instr    = q_instr[head];
      instr_pc = q_pc[head];
    end else begin
      instr    = 32'h0;
      instr_pc = 32'h0;
    end
    pop  = instr_valid && instr_ready;
    push = (state == WAIT) && imem_rvalid && !redirect_valid && !reset;
  end

  // A request still in flight across reset must not be captured later, so
  // reset parks the FSM in DROP until that response shows up.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      tag_pc   <= RESET_PC;
      if ((state == WAIT || state == DROP) && !imem_rvalid) begin
        state <= DROP;
      end else begin
        state <= IDLE;
      end
    end else begin
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
      end else if (issue) begin
        fetch_pc <= fetch_pc + 32'd1;
        tag_pc   <= fetch_pc;
      end
      case (state)
        IDLE:    if (issue) state <= WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            state <= IDLE;
          end else if (redirect_valid) begin
            state <= DROP;
          end
        end
        DROP:    if (imem_rvalid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || redirect_valid) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        q_instr[tail] <= imem_rdata;
        q_pc[tail]    <= tag_pc;
        tail          <= tail + AW'(1);
      end
      if (pop) begin
        head <= head + AW'(1);
      end
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

endmodule

// File: tb/tb_prefetch_unit.sv
// Self-checking bench for prefetch_unit: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_prefetch_unit;

  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset, imem_req, imem_rvalid, redirect_valid;
  logic        instr_valid, instr_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;

  prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        r_reset, r_redirect, r_ready;
  logic [31:0] r_rpc;
  int          lat;

  bit          mem_pend;
  logic [31:0] mem_addr;
  int          mem_cnt;

  logic [63:0] m_q[$];
  logic [31:0] m_pc, m_tag;
  bit          m_out, m_keep;

  logic [31:0] iss_log[$];
  logic [31:0] dlv_log[$];
  logic [31:0] dlv_data[$];
  logic        s_valid, s_req;
  logic [31:0] s_instr, s_pc, s_addr;
  bit          found;
  logic [31:0] stale;
  int          bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  // One clock cycle: drive inputs and memory, compare DUT to model, advance model.
  task automatic step();
    logic        ev, er, xfer;
    logic [31:0] ei, ep;
    @(negedge clk);
    reset          = r_reset;
    redirect_valid = r_redirect;
    redirect_pc    = r_rpc;
    instr_ready    = r_ready;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1000 + mem_addr;
        mem_pend    = 1'b0;
      end
    end
    #1;
    ev = !reset && (m_q.size() != 0);
    ei = ev ? m_q[0][63:32] : 32'h0;
    ep = ev ? m_q[0][31:0]  : 32'h0;
    er = !reset && !redirect_valid && !m_out && (m_q.size() < DEPTH);
    chk("instr_valid", 32'(instr_valid), 32'(ev));
    chk("instr", instr, ei);
    chk("instr_pc", instr_pc, ep);
    chk("imem_req", 32'(imem_req), 32'(er));
    if (er) chk("imem_addr", imem_addr, m_pc);
    s_valid = instr_valid; s_req = imem_req;
    s_instr = instr; s_pc = instr_pc; s_addr = imem_addr;
    xfer = ev && instr_ready;
    if (xfer) begin
      dlv_log.push_back(ep);
      dlv_data.push_back(ei);
    end
    if (imem_req) begin
      mem_pend = 1'b1; mem_addr = imem_addr; mem_cnt = lat;
      iss_log.push_back(imem_addr);
    end
    if (reset) begin
      m_q.delete();
      m_pc = RESET_PC;
      if (m_out && imem_rvalid) m_out = 1'b0;
      else if (m_out) m_keep = 1'b0;
    end else begin
      if (xfer) void'(m_q.pop_front());
      if (imem_rvalid && m_out) begin
        if (m_keep && !redirect_valid) m_q.push_back({imem_rdata, m_tag});
        m_out = 1'b0;
      end
      if (redirect_valid) begin
        m_q.delete();
        m_pc   = redirect_pc;
        m_keep = 1'b0;
      end else if (er) begin
        m_out = 1'b1; m_keep = 1'b1; m_tag = m_pc; m_pc = m_pc + 32'd1;
      end
    end
    @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    r_reset = 1'b1; r_redirect = 1'b0; r_rpc = 32'h0; r_ready = 1'b0; lat = 1;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    mem_pend = 1'b0; mem_cnt = 0; mem_addr = 32'h0;
    m_pc = RESET_PC; m_tag = 32'h0; m_out = 1'b0; m_keep = 1'b0;

    // Fill the queue with decode stalled, 1-cycle memory.
    repeat (3) step();
    chk("rst_valid", 32'(s_valid), 32'd0);
    chk("rst_req", 32'(s_req), 32'd0);
    r_reset = 1'b0;
    iss_log.delete();
    repeat (12) step();
    chk("fill_iss_n", iss_log.size(), 32'd4);
    for (int i = 0; i < 4; i++) chk("fill_iss_addr", qget(iss_log, i), 32'(i));
    chk("fill_req", 32'(s_req), 32'd0);
    chk("fill_valid", 32'(s_valid), 32'd1);
    chk("fill_instr", s_instr, 32'h1000);
    chk("fill_pc", s_pc, 32'h0);
    chk("fill_model_n", m_q.size(), 32'd4);

    // Streaming with 3-cycle latency.
    lat = 3; r_ready = 1'b1;
    dlv_log.delete(); dlv_data.delete();
    repeat (40) step();
    chk("stream_n_ge10", 32'(dlv_log.size() >= 10), 32'd1);
    for (int i = 0; i < dlv_log.size(); i++) begin
      chk("stream_pc", dlv_log[i], 32'(i));
      chk("stream_data", dlv_data[i], 32'h1000 + 32'(i));
    end

    // Redirect while the address-5 request is outstanding, queue non-empty.
    r_reset = 1'b1; repeat (2) step(); r_reset = 1'b0;
    iss_log.delete();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      r_ready = (iss_log.size() < 3);
      step();
      if (mem_pend && mem_addr == 32'h5) found = 1'b1;
    end
    chk("reach_addr5", 32'(found), 32'd1);
    iss_log.delete(); dlv_log.delete(); dlv_data.delete();
    r_redirect = 1'b1; r_rpc = 32'h40;
    step();
    r_redirect = 1'b0; r_ready = 1'b1;
    step();
    chk("redir_flush", 32'(s_valid), 32'd0);
    repeat (20) step();
    chk("redir_first_addr", qget(iss_log, 0), 32'h40);
    chk("redir_first_pc", qget(dlv_log, 0), 32'h40);
    bad = 0;
    foreach (dlv_log[i]) if (dlv_log[i] == 32'h5) bad++;
    chk("redir_addr5_dropped", 32'(bad), 32'd0);

    // Redirect coinciding with a response.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_pend && mem_cnt == 1) found = 1'b1;
      else step();
    end
    chk("coincide_setup", 32'(found), 32'd1);
    stale = mem_addr;
    r_redirect = 1'b1; r_rpc = 32'h80;
    step();
    r_redirect = 1'b0;
    dlv_log.delete(); dlv_data.delete(); iss_log.delete();
    step();
    chk("coincide_req", 32'(s_req), 32'd1);
    chk("coincide_addr", s_addr, 32'h80);
    repeat (10) step();
    bad = 0;
    foreach (dlv_log[i]) if (dlv_log[i] == stale) bad++;
    chk("coincide_stale", 32'(bad), 32'd0);
    chk("coincide_first_pc", qget(dlv_log, 0), 32'h80);

    // Reset with two entries queued and one request in flight.
    lat = 2; r_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (m_q.size() == 2 && mem_pend && mem_cnt == 2) found = 1'b1;
    end
    chk("rst_mid_setup", 32'(found), 32'd1);
    iss_log.delete(); dlv_log.delete(); dlv_data.delete();
    r_reset = 1'b1; step(); r_reset = 1'b0;
    step();
    chk("rst_mid_valid", 32'(s_valid), 32'd0);
    chk("rst_mid_req_drop", 32'(s_req), 32'd0);
    r_ready = 1'b1;
    repeat (10) step();
    chk("rst_mid_first_addr", qget(iss_log, 0), RESET_PC);
    chk("rst_mid_first_pc", qget(dlv_log, 0), RESET_PC);
    chk("rst_mid_first_data", qget(dlv_data, 0), 32'h1000 + RESET_PC);

    // PC wrap at the top of the address space.
    lat = 1;
    r_redirect = 1'b1; r_rpc = 32'hFFFF_FFFF;
    step();
    r_redirect = 1'b0;
    iss_log.delete(); dlv_log.delete(); dlv_data.delete();
    repeat (10) step();
    chk("wrap_iss0", qget(iss_log, 0), 32'hFFFF_FFFF);
    chk("wrap_iss1", qget(iss_log, 1), 32'h0);
    chk("wrap_pc0", qget(dlv_log, 0), 32'hFFFF_FFFF);
    chk("wrap_pc1", qget(dlv_log, 1), 32'h0);
    chk("wrap_data0", qget(dlv_data, 0), 32'h0000_0FFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
